// File: rtl/fnd_button_ctrl.sv
// Two-button conditioner: 2-FF sync, debounce FSM, toggled level output and one-cycle press pulse per button.
// Optional FND_LONGPRESS_EN: the on/off button acts only after a long hold instead of a short press.
module fnd_button_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DEBOUNCE_MS  = 10,
    parameter int LONGPRESS_MS = 1000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_mode,
    input  logic i_btn_onoff,
    output logic o_modeSW,
    output logic o_OnOffSW,
    output logic o_mode_pulse,
    output logic o_onoff_pulse
);
    localparam int DB_RAW  = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LP_RAW  = CLK_HZ / 1000 * LONGPRESS_MS;
    localparam int DB_CNT  = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int LP_CNT  = (LP_RAW < 1) ? 1 : LP_RAW;
    localparam int CNT_MAX = (DB_CNT > LP_CNT) ? DB_CNT : LP_CNT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT - 1);
`ifdef FND_LONGPRESS_EN
    localparam logic [CW-1:0] LP_LAST = CW'(LP_CNT - 1);
    localparam logic [CW-1:0] LP_TOP  = CW'(LP_CNT);
`endif

    typedef enum logic [1:0] {S_REL, S_PDB, S_PRS, S_RDB} state_t;

    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_pulse;

    assign w_raw = {i_btn_onoff, i_btn_mode};

    // Index 0 is the mode button, index 1 the on/off button.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            localparam logic LEVEL_RST = (gi == 1);
`ifdef FND_LONGPRESS_EN
            localparam logic LONG_ONLY = (gi == 1);
`else
            localparam logic LONG_ONLY = 1'b0;
`endif
            logic [1:0]    r_sync;
            state_t        r_state;
            logic [CW-1:0] r_cnt;
            logic          r_pulse;
            logic          r_level;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    r_sync  <= 2'b00;
                    r_state <= S_REL;
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                    r_level <= LEVEL_RST;
                end else begin
                    r_sync  <= {r_sync[0], w_raw[gi]};
                    r_pulse <= 1'b0;
                    case (r_state)
                        S_REL: begin
                            if (r_sync[1]) begin
                                r_state <= S_PDB;
                                r_cnt   <= '0;
                            end
                        end
                        S_PDB: begin
                            if (!r_sync[1]) begin
                                r_state <= S_REL;
                            end else if (r_cnt == DB_LAST) begin
                                r_state <= S_PRS;
                                r_cnt   <= '0;
                                if (!LONG_ONLY) begin
                                    r_pulse <= 1'b1;
                                    r_level <= ~r_level;
                                end
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        S_PRS: begin
                            if (!r_sync[1]) begin
                                r_state <= S_RDB;
                                r_cnt   <= '0;
                            end
`ifdef FND_LONGPRESS_EN
                            // Hold timer saturates so a long press fires exactly once.
                            else if (r_cnt == LP_LAST) begin
                                r_cnt <= LP_TOP;
                                if (LONG_ONLY) begin
                                    r_pulse <= 1'b1;
                                    r_level <= ~r_level;
                                end
                            end else if (r_cnt != LP_TOP) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
`endif
                        end
                        S_RDB: begin
                            if (r_sync[1]) begin
                                r_state <= S_PRS;
                                r_cnt   <= '0;
                            end else if (r_cnt == DB_LAST) begin
                                r_state <= S_REL;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: r_state <= S_REL;
                    endcase
                end
            end

            assign w_level[gi] = r_level;
            assign w_pulse[gi] = r_pulse;
        end
    endgenerate

    assign o_modeSW      = w_level[0];
    assign o_OnOffSW     = w_level[1];
    assign o_mode_pulse  = w_pulse[0];
    assign o_onoff_pulse = w_pulse[1];
endmodule

// File: tb/tb_fnd_button_ctrl.sv
// Bench for fnd_button_ctrl: run-length debounce model checked every cycle, plus directed latency/toggle checks.
`timescale 1ns/1ps
module tb_fnd_button_ctrl;
    localparam int DB_CNT = 4;
`ifdef FND_LONGPRESS_EN
    localparam int  LP_CNT    = 20;
    localparam bit  LONGPRESS = 1'b1;
`else
    localparam bit  LONGPRESS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_onoff = 1'b0;
    logic o_modeSW, o_OnOffSW, o_mode_pulse, o_onoff_pulse;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int t_set = 0;
    int n_mp = 0;
    int n_op = 0;
    int last_mp = -1;
    int last_op = -1;
    logic mode_at_mp = 1'b0;

    // Model: debounced level flips once the synchronised input has held a new value for DB_CNT+1 samples.
    logic [1:0] m_s1, m_s2, m_deb, m_run_val, m_pulse, m_level;
    int m_run [2];
`ifdef FND_LONGPRESS_EN
    int m_lp;
`endif

    always #5 clk = ~clk;

    fnd_button_ctrl #(
        .CLK_HZ(1000),
        .DEBOUNCE_MS(4),
        .LONGPRESS_MS(20)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_btn_mode(btn_mode),
        .i_btn_onoff(btn_onoff),
        .o_modeSW(o_modeSW),
        .o_OnOffSW(o_OnOffSW),
        .o_mode_pulse(o_mode_pulse),
        .o_onoff_pulse(o_onoff_pulse)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_run_val = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_pulse = '0; m_level = 2'b10;
`ifdef FND_LONGPRESS_EN
        m_lp = 0;
`endif
    endtask

    task automatic model_step();
        logic [1:0] raw;
        logic [1:0] fire;
        logic sb;
        raw  = {btn_onoff, btn_mode};
        fire = '0;
        for (int b = 0; b < 2; b++) begin
            sb = m_s2[b];
            if (sb == m_run_val[b]) begin
                if (m_run[b] < 1000000) m_run[b]++;
            end else begin
                m_run_val[b] = sb;
                m_run[b] = 1;
            end
            if (sb != m_deb[b] && m_run[b] >= DB_CNT + 1) begin
                m_deb[b] = sb;
                if (sb) begin
                    fire[b] = (b == 0) || !LONGPRESS;
`ifdef FND_LONGPRESS_EN
                    if (b == 1) m_lp = 0;
`endif
                end
            end
`ifdef FND_LONGPRESS_EN
            else if (b == 1 && m_deb[1]) begin
                if (!sb) m_lp = 0;
                else if (m_run[1] > 1 && m_lp < LP_CNT) begin
                    m_lp++;
                    if (m_lp == LP_CNT) fire[1] = 1'b1;
                end
            end
`endif
        end
        m_pulse = fire;
        m_level ^= fire;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle compare against the model, plus pulse bookkeeping for the directed checks.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if ({o_onoff_pulse, o_mode_pulse, o_OnOffSW, o_modeSW} === {m_pulse, m_level}) n_pass++;
            else $display("FAIL cycle %0d outputs {onoff_p,mode_p,OnOff,mode}: got %b, expected %b",
                          cyc, {o_onoff_pulse, o_mode_pulse, o_OnOffSW, o_modeSW}, {m_pulse, m_level});
            if (o_mode_pulse === 1'b1) begin
                n_mp++;
                last_mp = cyc;
                mode_at_mp = o_modeSW;
            end
            if (o_onoff_pulse === 1'b1) begin
                n_op++;
                last_op = cyc;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic drive(input logic m, input logic o, input int n);
        #1;
        btn_mode = m;
        btn_onoff = o;
        t_set = cyc;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pm, po, pm0, r;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Idle after reset
        drive(0, 0, 50);
        check("idle mode pulses", n_mp, 0);
        check("idle onoff pulses", n_op, 0);
        check("idle modeSW", o_modeSW, 0);
        check("idle OnOffSW", o_OnOffSW, 1);

        // Clean mode press
        pm = n_mp;
        drive(1, 0, 10);
        r = t_set;
        drive(0, 0, 10);
        check("clean press count", n_mp - pm, 1);
        check("clean press latency", last_mp - r, 7);
        check("clean level at pulse", mode_at_mp, 1);
        check("clean modeSW", o_modeSW, 1);

        // Bounce then stable
        pm = n_mp;
        drive(1, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 12);
        r = t_set;
        drive(0, 0, 10);
        check("bounce press count", n_mp - pm, 1);
        check("bounce latency", last_mp - r, 7);
        check("bounce modeSW", o_modeSW, 0);

        // Both buttons together
        pm = n_mp;
        po = n_op;
        drive(1, 1, 10);
        drive(0, 0, 10);
        check("dual mode count", n_mp - pm, 1);
        check("dual modeSW", o_modeSW, 1);
        if (LONGPRESS) begin
            check("dual onoff count", n_op - po, 0);
            check("dual OnOffSW", o_OnOffSW, 1);
        end else begin
            check("dual onoff count", n_op - po, 1);
            check("dual same cycle", last_op - last_mp, 0);
            check("dual OnOffSW", o_OnOffSW, 0);
        end

        // Short on/off glitch, then long hold
        po = n_op;
        drive(0, 1, 3);
        drive(0, 0, 10);
        check("short onoff count", n_op - po, 0);
        check("short OnOffSW", o_OnOffSW, LONGPRESS ? 1 : 0);
        po = n_op;
        drive(0, 1, 40);
        r = t_set;
        drive(0, 0, 10);
        check("hold onoff count", n_op - po, 1);
        check("hold onoff latency", last_op - r, LONGPRESS ? 27 : 7);
        check("hold OnOffSW", o_OnOffSW, LONGPRESS ? 0 : 1);

        // Reset mid-debounce with mode held across release
        pm0 = n_mp;
        drive(1, 0, 4);
        #1 rst_n = 1'b0;
        #1;
        check("async reset outputs", {o_onoff_pulse, o_mode_pulse, o_OnOffSW, o_modeSW}, 4'b0010);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        r = cyc;
        pm = n_mp;
        repeat (12) @(negedge clk);
        check("held-through-reset count", n_mp - pm, 1);
        check("held-through-reset total", n_mp - pm0, 1);
        check("held-through-reset latency", last_mp - r, 7);
        check("held-through-reset modeSW", o_modeSW, 1);
        drive(0, 0, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
